vpu_src_rd_arb: RTL

VPU_SRC_RD_ARB -- requirements
Module: vpu_src_rd_arb

---
 rtl/vpu_pkg.sv | 21 ++
 rtl/vpu_src_rd_arb_if.sv | 38 +++
 rtl/vpu_tag_fifo.sv | 48 ++++
 rtl/vpu_src_rd_arb.sv | 119 +++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared VPU SRAM geometry, source-read arbiter constants and state type
package vpu_pkg;

    localparam int SRAM_BANK_CNT_LG2    = 2;
    localparam int SRAM_BANK_DEPTH_LG2  = 8;
    localparam int SRAM_DATA_WIDTH      = 32;

    localparam int SRC_RD_ARB_N_REQ     = 3;
    localparam int SRC_RD_ARB_TAG_DEPTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } vpu_arb_state_t;

    // Index width that stays legal when there is only one requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vpu_src_rd_arb_if.sv
// rtl/vpu_src_rd_arb_if.sv - requester-side and SRAM-side read port bundle for the source-read arbiter
interface vpu_src_rd_arb_if import vpu_pkg::*; #(
    parameter int N_REQ = SRC_RD_ARB_N_REQ
);

    logic [N_REQ-1:0]                          up_req;
    logic [N_REQ-1:0]                          up_ack;
    logic [N_REQ-1:0][SRAM_BANK_CNT_LG2-1:0]   up_rid;
    logic [N_REQ-1:0][SRAM_BANK_DEPTH_LG2-1:0] up_addr;
    logic [N_REQ-1:0]                          up_reb;
    logic [N_REQ-1:0]                          up_rlast;
    logic [SRAM_DATA_WIDTH-1:0]                up_rdata;
    logic [N_REQ-1:0]                          up_rvalid;

    logic                                      dn_req;
    logic [SRAM_BANK_CNT_LG2-1:0]              dn_rid;
    logic [SRAM_BANK_DEPTH_LG2-1:0]            dn_addr;
    logic                                      dn_reb;
    logic                                      dn_rlast;
    logic                                      dn_ack;
    logic [SRAM_DATA_WIDTH-1:0]                dn_rdata;
    logic                                      dn_rvalid;

    modport slave (
        input  up_req, up_rid, up_addr, up_reb, up_rlast,
        input  dn_ack, dn_rdata, dn_rvalid,
        output up_ack, up_rdata, up_rvalid,
        output dn_req, dn_rid, dn_addr, dn_reb, dn_rlast
    );

    modport master (
        output up_req, up_rid, up_addr, up_reb, up_rlast,
        output dn_ack, dn_rdata, dn_rvalid,
        input  up_ack, up_rdata, up_rvalid,
        input  dn_req, dn_rid, dn_addr, dn_reb, dn_rlast
    );

endinterface

// File: rtl/vpu_tag_fifo.sv
// rtl/vpu_tag_fifo.sv - small order-tracking FIFO holding the requester index of each outstanding read
module vpu_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vpu_src_rd_arb.sv
// rtl/vpu_src_rd_arb.sv - round-robin arbiter sharing one SRAM read port among source-read requesters
module vpu_src_rd_arb import vpu_pkg::*; #(
    parameter int N_REQ     = SRC_RD_ARB_N_REQ,
    parameter int TAG_DEPTH = SRC_RD_ARB_TAG_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    vpu_src_rd_arb_if.slave   bus,
    output logic              err_underflow
);

    localparam int IDX_W = idx_width(N_REQ);

    vpu_arb_state_t   state;
    vpu_arb_state_t   state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W-1:0] rr_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] fifo_head;

    logic             beat_acc;
    logic             burst_done;
    logic             rd_pop;

    assign beat_acc   = bus.dn_req && bus.dn_ack;
    assign burst_done = beat_acc && bus.dn_rlast;
    assign rd_pop     = bus.dn_rvalid && !fifo_empty;
    assign rr_next    = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Scan from rr_ptr downward in priority so the closest requester after rr_ptr wins.
    always_comb begin : rr_pick
        logic [IDX_W:0] sum;
        sum       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            if (bus.up_req[sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == BUSY) begin
                grant_idx <= win_idx;
            end
            if (burst_done) begin
                rr_ptr <= rr_next;
            end
            if (bus.dn_rvalid && fifo_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_found && !fifo_full) state_nxt = BUSY;
            BUSY: if (burst_done)              state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.dn_req    = 1'b0;
        bus.dn_rid    = '0;
        bus.dn_addr   = '0;
        bus.dn_reb    = 1'b1;
        bus.dn_rlast  = 1'b0;
        bus.up_ack    = '0;
        bus.up_rdata  = bus.dn_rdata;
        bus.up_rvalid = '0;
        if (state == BUSY) begin
            // Full is the registered FIFO state, so a same-cycle pop cannot unblock a push.
            bus.dn_req            = bus.up_req[grant_idx] && !fifo_full;
            bus.dn_rid            = bus.up_rid[grant_idx];
            bus.dn_addr           = bus.up_addr[grant_idx];
            bus.dn_reb            = bus.up_reb[grant_idx];
            bus.dn_rlast          = bus.up_rlast[grant_idx];
            bus.up_ack[grant_idx] = bus.dn_ack && bus.up_req[grant_idx] && !fifo_full;
        end
        if (rd_pop) begin
            bus.up_rvalid[fifo_head] = 1'b1;
        end
    end

    vpu_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (beat_acc),
        .push_data (grant_idx),
        .pop       (rd_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule
